dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Two-requester round-robin arbiter and sequencer placed in front of the single-port `dummy_dram`. It accepts load/store requests from two clients, such as the data-cache controller and a refill/writeback engine. It serialises them onto the DRAM's `mem_req`/`mem_ready` interface, captures read data one cycle after issue, and returns a one-cycle completion pulse to the granted client. Only one transaction is outstanding at any time.

## Interface
- `DATA`, 11: data width; matches the DRAM `data` parameter.
- `TIMEOUT`, 15: cycles ISSUE may wait for `mem_ready` before aborting. Used only with `DRAM_ARB_TIMEOUT_EN`; must be ≥1.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-client request; bit *i* is held high until `rsp_done[i]`.
- `req_we`  in  2  per-client op: 0 = LW (read), 1 = SW (write).
- `req_addr0`, `req_addr1`  in  32 each  client addresses.
- `req_wdata0`, `req_wdata1`  in  DATA each  client store data.
- `rsp_done`  out  2  one-cycle completion pulse to the granted client.
- `rsp_data`  out  DATA  read data; valid while `rsp_done` is high and held until the next RESP.
- `rsp_err`  out  1  timeout abort flag, pulsed with `rsp_done`. Tied 0 without the macro.
- `busy`  out  1  high in every state except IDLE.
- `mem_address`  out  32  to DRAM `mem_address`.
- `lsu_operator`  out  1  to DRAM `lsu_operator`.
- `mem_req`  out  1  to DRAM `mem_req`.
- `write_data_int`  out  DATA  to DRAM `write_data_int`.
- `mem_ready`  in  1  from DRAM.
- `dram_data_out`  in  DATA  from DRAM; registered one cycle after an accepted read.

## Operation
- FSM states are IDLE, ISSUE, CAPTURE and RESP.
- **IDLE**
  - If any `req_valid` bit is set, select a winner and latch its we/addr/wdata into internal registers, then go to ISSUE.
  - Selection rule: a lone requester wins. If both request, the client ≠ `last_gnt` wins.
- **ISSUE**
  - Drive `mem_req`=1 and drive `mem_address`/`lsu_operator`/`write_data_int` from the latched registers.
  - If `mem_ready` is sampled high, go to CAPTURE for a read or to RESP for a write.
  - Otherwise stay in ISSUE.
- **CAPTURE**
  - `mem_req`=0.
  - Latch `dram_data_out` into `rsp_data`, then go to RESP.
- **RESP**
  - Pulse `rsp_done[gnt]`=1 for one cycle and set `last_gnt` ← gnt, then go to IDLE.
  - `rsp_data` is unchanged for writes.
- Requester inputs are latched at grant. Changes to them after grant do not affect the in-flight transaction.
- A client that keeps `req_valid` high after its own `rsp_done` is treated as a new request in the next IDLE cycle.
- The address passes through unmodified; only [9:0] is significant downstream.
- `mem_address`, `lsu_operator` and `write_data_int` hold their last values outside ISSUE.

## Timing
- Reset values:
  - All outputs are 0 and the FSM is in IDLE.
  - `last_gnt`=1, so client 0 wins the first contention.
  - The timeout counter is 0.
- Reset assertion mid-transaction:
  - Immediately returns the FSM to IDLE and clears all outputs.
  - The in-flight request is dropped with no `rsp_done`.
  - A DRAM write already sampled is not undone.
- Latency, with request seen in IDLE at cycle 0 and `mem_ready` immediate:
  - Read: ISSUE at cycle 1, CAPTURE at cycle 2, `rsp_done` at cycle 3.
  - Write: ISSUE at cycle 1, `rsp_done` at cycle 2.
  - Each extra cycle of `mem_ready` low adds one cycle.
- Back-to-back operation: RESP → IDLE costs one cycle. The minimum issue spacing is 4 cycles for reads and 3 cycles for writes.
- `busy` is 0 only in IDLE.

## Configuration
- `DRAM_ARB_TIMEOUT_EN` defined:
  - A counter increments on every ISSUE cycle with `mem_ready` low.
  - On reaching `TIMEOUT`, the FSM drops `mem_req` and goes to RESP with `rsp_err`=1 and `rsp_data`=0.
  - The counter clears on leaving ISSUE.
- Not defined:
  - ISSUE waits indefinitely.
  - `rsp_err` is constant 0 and no counter is synthesised.

## Test plan
- Single read: preload DRAM[0x005]=0x2A5. Client 0 reads 0x005 with `mem_ready` immediate → `rsp_done`=2'b01 at cycle 3 with `rsp_data`=0x2A5 and `rsp_err`=0.
- Single write then read: client 1 writes 0x155 to 0x3FF and completes at cycle 2 (`rsp_done`=2'b10). Client 1 then reads 0x3FF → `rsp_data`=0x155.
- Contention: both clients hold reads (0x001, 0x002) from reset → client 0 is served first, then client 1. With both requesting continuously, grants alternate 0,1,0,1 over 4 transactions.
- Stall: force `mem_ready` low for 3 ISSUE cycles → `mem_req` stays high throughout, and `rsp_done` arrives at cycle 6 for a read.
- Reset mid-transaction: assert `rst`=0 during CAPTURE → outputs are 0 immediately, with no `rsp_done`. After release, a fresh client 1 request is served normally.
- Timeout (macro defined, `TIMEOUT`=15): hold `mem_ready` low → after 15 ISSUE cycles, `rsp_done` and `rsp_err` pulse with `rsp_data`=0 and `mem_req`=0. Without the macro, `mem_req` is still 1 at cycle 100.

Source files
------------

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-client round-robin arbiter/sequencer for the single-port dummy_dram
// Optional ISSUE timeout abort is enabled by defining DRAM_ARB_TIMEOUT_EN.
module dram_arbiter #(
    parameter int DATA    = 11,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    input  logic [1:0]      req_we,
    input  logic [31:0]     req_addr0,
    input  logic [31:0]     req_addr1,
    input  logic [DATA-1:0] req_wdata0,
    input  logic [DATA-1:0] req_wdata1,
    output logic [1:0]      rsp_done,
    output logic [DATA-1:0] rsp_data,
    output logic            rsp_err,
    output logic            busy,
    output logic [31:0]     mem_address,
    output logic            lsu_operator,
    output logic            mem_req,
    output logic [DATA-1:0] write_data_int,
    input  logic            mem_ready,
    input  logic [DATA-1:0] dram_data_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t          state, state_nxt;
    logic            sel;
    logic            gnt;
    logic            last_gnt;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [DATA-1:0] wdata_q;
    logic [DATA-1:0] data_q;
    logic            timeout_hit;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("dram_arbiter: TIMEOUT must be >= 1");
    end

`ifdef DRAM_ARB_TIMEOUT_EN
    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;
    logic          err_q;

    // The stall that would bring the count to TIMEOUT aborts instead of counting.
    assign timeout_hit = (state == ISSUE) && !mem_ready && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ISSUE && !mem_ready && !timeout_hit)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (timeout_hit)
                err_q <= 1'b1;
            else if (state == IDLE)
                err_q <= 1'b0;
        end
    end

    assign rsp_err = (state == RESP) && err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // Lone requester wins; under contention the client not granted last time wins.
    always_comb begin
        sel = req_valid[1];
        if (req_valid == 2'b11)
            sel = ~last_gnt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid) state_nxt = ISSUE;
            ISSUE: begin
                if (mem_ready)
                    state_nxt = we_q ? RESP : CAPTURE;
                else if (timeout_hit)
                    state_nxt = RESP;
            end
            CAPTURE: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        gnt     <= sel;
                        we_q    <= req_we[sel];
                        addr_q  <= sel ? req_addr1 : req_addr0;
                        wdata_q <= sel ? req_wdata1 : req_wdata0;
                    end
                end
                ISSUE:   if (timeout_hit) data_q <= '0;
                CAPTURE: data_q <= dram_data_out;
                RESP:    last_gnt <= gnt;
                default: ;
            endcase
        end
    end

    // Latched registers only change on grant, so the DRAM side holds its last values outside ISSUE.
    assign mem_address    = addr_q;
    assign lsu_operator   = we_q;
    assign write_data_int = wdata_q;
    assign mem_req        = (state == ISSUE);
    assign busy           = (state != IDLE);
    assign rsp_data       = data_q;
    assign rsp_done       = (state == RESP) ? (gnt ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - randomized self-checking bench for dram_arbiter with a DRAM model and scoreboard
module tb_dram_arbiter;
    localparam int DATA = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_we;
    logic [31:0]     req_addr0, req_addr1;
    logic [DATA-1:0] req_wdata0, req_wdata1;
    logic [1:0]      rsp_done;
    logic [DATA-1:0] rsp_data;
    logic            rsp_err;
    logic            busy;
    logic [31:0]     mem_address;
    logic            lsu_operator;
    logic            mem_req;
    logic [DATA-1:0] write_data_int;
    logic            mem_ready;
    logic [DATA-1:0] dram_data_out;

    logic [DATA-1:0] dram    [1024];
    logic [DATA-1:0] ref_mem [1024];
    logic            last;
    int              checks   = 0;
    int              failures = 0;

    always #5 clk = ~clk;

    dram_arbiter #(.DATA(DATA), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .rsp_done(rsp_done), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .mem_address(mem_address), .lsu_operator(lsu_operator), .mem_req(mem_req),
        .write_data_int(write_data_int), .mem_ready(mem_ready), .dram_data_out(dram_data_out)
    );

    // Single-port DRAM: writes land on an accepted request, reads return one cycle later.
    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            if (lsu_operator) dram[mem_address[9:0]] <= write_data_int;
            else              dram_data_out <= dram[mem_address[9:0]];
        end
    end

    task automatic drive_req(input int c, input logic we, input logic [31:0] a, input logic [DATA-1:0] d);
        req_valid[c] = 1'b1;
        req_we[c]    = we;
        if (c == 0) begin req_addr0 = a; req_wdata0 = d; end
        else        begin req_addr1 = a; req_wdata1 = d; end
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); @(negedge clk);
            if (rsp_done != 2'b00) begin cyc = n; break; end
        end
    endtask

    task automatic finish_txn();
        req_valid = 2'b00;
        mem_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        last = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 2'b00; req_we = 2'b00; mem_ready = 1'b1;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        repeat (2) @(negedge clk);
        checks++; if ({rsp_done, busy, mem_req, rsp_err, lsu_operator} !== 6'b0) begin failures++;
            $display("FAIL reset_ctrl: got %b expected 000000", {rsp_done, busy, mem_req, rsp_err, lsu_operator}); end
        checks++; if (mem_address !== 32'h0) begin failures++;
            $display("FAIL reset_addr: got %h expected 0", mem_address); end
        checks++; if (rsp_data !== '0 || write_data_int !== '0) begin failures++;
            $display("FAIL reset_data: got rsp_data=%h wdata=%h expected 0", rsp_data, write_data_int); end
        rst = 1'b1;
        @(negedge clk);
        last = 1'b1;
        checks++; if (busy !== 1'b0 || rsp_done !== 2'b00) begin failures++;
            $display("FAIL reset_idle: got busy=%b done=%b expected 0/00", busy, rsp_done); end
    endtask

    task automatic test_single_read();
        int cyc;
        dram[5] = 11'h2A5; ref_mem[5] = 11'h2A5;
        drive_req(0, 1'b0, 32'h5, '0);
        @(posedge clk); @(negedge clk);
        checks++; if (busy !== 1'b1 || mem_req !== 1'b1 || mem_address !== 32'h5) begin failures++;
            $display("FAIL read_issue: got busy=%b mem_req=%b addr=%h expected 1/1/5", busy, mem_req, mem_address); end
        wait_done(20, cyc);
        cyc = (cyc < 0) ? cyc : cyc + 1;
        checks++; if (cyc != 3) begin failures++; $display("FAIL read_latency: got %0d expected 3", cyc); end
        checks++; if (rsp_done !== 2'b01) begin failures++; $display("FAIL read_done: got %b expected 01", rsp_done); end
        checks++; if (rsp_data !== 11'h2A5 || rsp_err !== 1'b0) begin failures++;
            $display("FAIL read_data: got %h err=%b expected 2a5 err=0", rsp_data, rsp_err); end
        last = 1'b0;
        finish_txn();
    endtask

    task automatic test_write_read();
        int cyc;
        drive_req(1, 1'b1, 32'h3FF, 11'h155);
        wait_done(20, cyc);
        checks++; if (cyc != 2 || rsp_done !== 2'b10) begin failures++;
            $display("FAIL write_done: got cycle %0d done=%b expected 2/10", cyc, rsp_done); end
        ref_mem[10'h3FF] = 11'h155;
        last = 1'b1;
        finish_txn();
        drive_req(1, 1'b0, 32'h3FF, '0);
        wait_done(20, cyc);
        checks++; if (cyc != 3 || rsp_done !== 2'b10) begin failures++;
            $display("FAIL wr_rd_done: got cycle %0d done=%b expected 3/10", cyc, rsp_done); end
        checks++; if (rsp_data !== ref_mem[10'h3FF]) begin failures++;
            $display("FAIL wr_rd_data: got %h expected %h", rsp_data, ref_mem[10'h3FF]); end
        finish_txn();
    endtask

    task automatic test_contention();
        int cyc;
        logic w;
        logic [9:0] a;
        do_reset();
        drive_req(0, 1'b0, 32'h1, '0);
        drive_req(1, 1'b0, 32'h2, '0);
        for (int t = 0; t < 4; t++) begin
            w = ~last;
            a = w ? 10'h2 : 10'h1;
            wait_done(20, cyc);
            checks++; if (rsp_done !== (w ? 2'b10 : 2'b01)) begin failures++;
                $display("FAIL contention_gnt%0d: got %b expected client %0d", t, rsp_done, w); end
            checks++; if (rsp_data !== ref_mem[a]) begin failures++;
                $display("FAIL contention_data%0d: got %h expected %h", t, rsp_data, ref_mem[a]); end
            checks++; if (cyc != ((t == 0) ? 3 : 4)) begin failures++;
                $display("FAIL contention_spacing%0d: got %0d expected %0d", t, cyc, (t == 0) ? 3 : 4); end
            last = w;
        end
        finish_txn();
    endtask

    task automatic test_stall();
        int cyc = -1;
        bit req_ok = 1'b1;
        logic [9:0] a = 10'($urandom);
        mem_ready = 1'b0;
        drive_req(0, 1'b0, {22'h0, a}, '0);
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); @(negedge clk);
            if (n <= 4 && mem_req !== 1'b1) req_ok = 1'b0;
            if (rsp_done != 2'b00) begin cyc = n; break; end
            mem_ready = (n >= 4);
        end
        checks++; if (!req_ok) begin failures++; $display("FAIL stall_mem_req: got a low cycle expected high 1..4"); end
        checks++; if (cyc != 6 || rsp_data !== ref_mem[a]) begin failures++;
            $display("FAIL stall_done: got cycle %0d data %h expected 6 data %h", cyc, rsp_data, ref_mem[a]); end
        last = 1'b0;
        finish_txn();
    endtask

    task automatic test_reset_mid();
        int cyc;
        int spurious = 0;
        drive_req(0, 1'b0, 32'h10, '0);
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if ({rsp_done, busy, mem_req, rsp_err, lsu_operator} !== 6'b0) begin failures++;
            $display("FAIL midrst_ctrl: got %b expected 000000", {rsp_done, busy, mem_req, rsp_err, lsu_operator}); end
        checks++; if (mem_address !== 32'h0 || rsp_data !== '0 || write_data_int !== '0) begin failures++;
            $display("FAIL midrst_data: got addr=%h data=%h wdata=%h expected 0", mem_address, rsp_data, write_data_int); end
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 6; n++) begin @(negedge clk); if (rsp_done != 2'b00) spurious++; end
        checks++; if (spurious != 0) begin failures++; $display("FAIL midrst_nodone: got %0d pulses expected 0", spurious); end
        last = 1'b1;
        drive_req(1, 1'b0, 32'h3FF, '0);
        wait_done(20, cyc);
        checks++; if (cyc != 3 || rsp_done !== 2'b10 || rsp_data !== ref_mem[10'h3FF]) begin failures++;
            $display("FAIL midrst_recover: got cycle %0d done=%b data=%h expected 3/10/%h", cyc, rsp_done, rsp_data, ref_mem[10'h3FF]); end
        finish_txn();
    endtask

    task automatic test_timeout();
        int cyc;
        logic [DATA-1:0] d = DATA'($urandom);
        mem_ready = 1'b0;
        drive_req(1, 1'b1, 32'h77, d);
`ifdef DRAM_ARB_TIMEOUT_EN
        wait_done(40, cyc);
        checks++; if (cyc != 16 || rsp_done !== 2'b10) begin failures++;
            $display("FAIL timeout_done: got cycle %0d done=%b expected 16/10", cyc, rsp_done); end
        checks++; if (rsp_err !== 1'b1 || rsp_data !== '0 || mem_req !== 1'b0) begin failures++;
            $display("FAIL timeout_flags: got err=%b data=%h mem_req=%b expected 1/0/0", rsp_err, rsp_data, mem_req); end
`else
        wait_done(100, cyc);
        checks++; if (cyc != -1 || mem_req !== 1'b1) begin failures++;
            $display("FAIL timeout_wait: got done cycle %0d mem_req=%b expected none/1", cyc, mem_req); end
        mem_ready = 1'b1;
        wait_done(10, cyc);
        checks++; if (cyc != 1 || rsp_done !== 2'b10 || rsp_err !== 1'b0) begin failures++;
            $display("FAIL timeout_release: got cycle %0d done=%b err=%b expected 1/10/0", cyc, rsp_done, rsp_err); end
        ref_mem[10'h77] = d;
`endif
        last = 1'b1;
        finish_txn();
    endtask

    task automatic test_random();
        int cyc;
        logic [1:0] v;
        logic w, exp_we;
        logic [31:0] exp_addr;
        logic [DATA-1:0] exp_wd;
        for (int t = 0; t < 40; t++) begin
            v = 2'($urandom_range(1, 3));
            req_valid = v; req_we = 2'($urandom);
            req_addr0 = $urandom; req_addr1 = $urandom;
            req_wdata0 = DATA'($urandom); req_wdata1 = DATA'($urandom);
            w = (v == 2'b11) ? ~last : v[1];
            exp_we   = req_we[w];
            exp_addr = w ? req_addr1 : req_addr0;
            exp_wd   = w ? req_wdata1 : req_wdata0;
            mem_ready = ($urandom_range(0, 3) != 0);
            cyc = -1;
            for (int n = 1; n <= 200; n++) begin
                @(posedge clk); @(negedge clk);
                if (n == 1) begin
                    req_we = 2'($urandom); req_addr0 = $urandom; req_addr1 = $urandom;
                    req_wdata0 = DATA'($urandom); req_wdata1 = DATA'($urandom);
                end
                if (rsp_done != 2'b00) begin cyc = n; break; end
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            checks++; if (cyc < 0 || rsp_done !== (w ? 2'b10 : 2'b01)) begin failures++;
                $display("FAIL rand_gnt%0d: got done=%b cycle %0d expected client %0d", t, rsp_done, cyc, w); end
            if (exp_we) begin
                ref_mem[exp_addr[9:0]] = exp_wd;
            end else begin
                checks++; if (rsp_data !== ref_mem[exp_addr[9:0]] || rsp_err !== 1'b0) begin failures++;
                    $display("FAIL rand_data%0d: got %h err=%b expected %h err=0", t, rsp_data, rsp_err, ref_mem[exp_addr[9:0]]); end
            end
            last = w;
            finish_txn();
        end
        // Every write in the run must have reached the DRAM model at the intended address.
        for (int i = 0; i < 1024; i++) begin
            if (dram[i] !== ref_mem[i]) begin
                checks++; failures++;
                $display("FAIL rand_mem[%0d]: got %h expected %h", i, dram[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            dram[i] = DATA'($urandom);
            ref_mem[i] = dram[i];
        end
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_stall();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
